// File: rtl/md_unit_iter_if.sv
// EX-stage request/response bundle for the iterative multiply/divide unit.
// start is a one-cycle strobe. It is accepted only while busy==0. busy is
// high for the whole operation, and hi/lo always show the committed registers.
interface md_unit_iter_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit_iter.sv
// Multi-cycle MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO.
// Uses sign-magnitude shift-add / restoring divide spread over the configured latency.
module md_unit_iter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    md_unit_iter_if.slave md,
    output logic          dbg_state
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MUL_STEPS = (32 + MULT_CYCLES - 1) / MULT_CYCLES;
    localparam int DIV_STEPS = (32 + DIV_CYCLES - 1) / DIV_CYCLES;
    localparam int MAX_STEPS = (MUL_STEPS > DIV_STEPS) ? MUL_STEPS : DIV_STEPS;
    localparam int MAX_CYC   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW        = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   b_q, b_d;
    logic          is_div_q, is_div_d;
    logic          neg_res_q, neg_res_d;
    logic          neg_rem_q, neg_rem_d;
    logic [63:0]   acc_q, acc_d;
    logic [5:0]    iter_q, iter_d;

    logic [63:0]   acc_nx;
    logic [5:0]    iter_nx;
    logic [32:0]   sum_t;
    logic [32:0]   rem_t;
    logic [32:0]   diff_t;
    logic [63:0]   mul_p;
    logic [31:0]   quo_s;
    logic [31:0]   rem_s;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic          sgn;
    int            steps_sel;

    // Datapath: acc holds {partial_hi, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        acc_nx    = acc_q;
        iter_nx   = iter_q;
        sum_t     = '0;
        rem_t     = '0;
        diff_t    = '0;
        steps_sel = is_div_q ? DIV_STEPS : MUL_STEPS;

        for (int i = 0; i < MAX_STEPS; i++) begin
            if (i < steps_sel && iter_nx < 6'd32) begin
                if (is_div_q) begin
                    rem_t  = {acc_nx[63:32], acc_nx[31]};
                    diff_t = rem_t - {1'b0, b_q};
                    // The shifted remainder is always below 2*divisor, so bit 32 is a clean borrow flag.
                    if (!diff_t[32]) begin
                        acc_nx = {diff_t[31:0], acc_nx[30:0], 1'b1};
                    end else begin
                        acc_nx = {acc_nx[62:0], 1'b0};
                    end
                end else begin
                    sum_t  = {1'b0, acc_nx[63:32]} + (acc_nx[0] ? {1'b0, b_q} : 33'd0);
                    acc_nx = {sum_t, acc_nx[31:1]};
                end
                iter_nx = iter_nx + 6'd1;
            end
        end

        mul_p = neg_res_q ? -acc_nx : acc_nx;
        quo_s = neg_res_q ? -acc_nx[31:0] : acc_nx[31:0];
        rem_s = neg_rem_q ? -acc_nx[63:32] : acc_nx[63:32];
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        iter_d    = iter_q;
        sgn       = ~md.md_op[0];
        a_mag     = (sgn && md.a[31]) ? -md.a : md.a;
        b_mag     = (sgn && md.b[31]) ? -md.b : md.b;

        case (state_q)
            IDLE: begin
                if (md.start) begin
                    case (md.md_op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            state_d   = RUN;
                            busy_d    = 1'b1;
                            is_div_d  = md.md_op[1];
                            neg_res_d = sgn & (md.a[31] ^ md.b[31]);
                            neg_rem_d = sgn & md.a[31];
                            b_d       = b_mag;
                            acc_d     = {32'd0, a_mag};
                            iter_d    = 6'd0;
                            cnt_d     = md.md_op[1] ? DIV_LOAD : MULT_LOAD;
                        end
                        3'b100:  hi_d = md.a;
                        3'b101:  lo_d = md.a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                acc_d  = acc_nx;
                iter_d = iter_nx;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    // Divide by zero runs the full latency but leaves HI/LO untouched.
                    if (!(is_div_q && b_q == 32'd0)) begin
                        if (is_div_q) begin
                            hi_d = rem_s;
                            lo_d = quo_s;
                        end else begin
                            hi_d = mul_p[63:32];
                            lo_d = mul_p[31:0];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            iter_q    <= iter_d;
        end
    end

    assign md.busy   = busy_q;
    assign md.hi     = hi_q;
    assign md.lo     = lo_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_md_unit_iter.sv
// Directed scoreboard bench for md_unit_iter: each completion (busy falling)
// is checked against a queued {busy_cycles, hi, lo} entry.
module tb_md_unit_iter;
    localparam int MC = 5;
    localparam int DC = 10;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NONE  = 3'b110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbg_state;

    md_unit_iter_if mif();

    md_unit_iter #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .md       (mif),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [95:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic monitor();
        logic        prev = 1'b0;
        int          cnt = 0;
        logic [95:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
                cnt  = 0;
            end else begin
                if (mif.busy) cnt++;
                if (prev && !mif.busy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: hi=%h lo=%h with empty queue", mif.hi, mif.lo);
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy_cycles", 32'(cnt), e[95:64]);
                        chk("hi", mif.hi, e[63:32]);
                        chk("lo", mif.lo, e[31:0]);
                    end
                    cnt = 0;
                end
                prev = mif.busy;
            end
        end
    endtask

    task automatic expect_res(input int dur, input logic [31:0] h, input logic [31:0] l);
        exp_q.push_back({32'(dur), h, l});
    endtask

    // Called just after a rising edge; holds start for exactly one cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        mif.start = 1'b1;
        mif.md_op = op;
        mif.a     = av;
        mif.b     = bv;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int busy_seen;
        mif.start = 1'b0;
        mif.md_op = 3'b000;
        mif.a     = 32'd0;
        mif.b     = 32'd0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, mif.busy}, 32'd0);
        chk("rst_hi", mif.hi, 32'd0);
        chk("rst_lo", mif.lo, 32'd0);
        chk("rst_state", {31'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        expect_res(MC, 32'hFFFFFFFF, 32'hFFFFFFFA);
        issue(OP_MULT, 32'hFFFFFFFE, 32'h00000003);
        drain();

        expect_res(MC, 32'h00000002, 32'hFFFFFFFA);
        issue(OP_MULTU, 32'hFFFFFFFE, 32'h00000003);
        drain();

        expect_res(DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
        drain();

        expect_res(DC, 32'd1, 32'd3);
        issue(OP_DIVU, 32'd7, 32'd2);
        drain();

        issue(OP_MTHI, 32'h11111111, 32'd0);
        issue(OP_MTLO, 32'h22222222, 32'd0);
        chk("mthi", mif.hi, 32'h11111111);
        chk("mtlo", mif.lo, 32'h22222222);
        chk("mt_busy", {31'd0, mif.busy}, 32'd0);

        issue(OP_NONE, 32'hAAAAAAAA, 32'h55555555);
        chk("noop_hi", mif.hi, 32'h11111111);
        chk("noop_lo", mif.lo, 32'h22222222);
        chk("noop_busy", {31'd0, mif.busy}, 32'd0);

        expect_res(DC, 32'h11111111, 32'h22222222);
        issue(OP_DIVU, 32'd7, 32'd0);
        drain();

        expect_res(DC, 32'h00000000, 32'h80000000);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        drain();

        // Second request in the very cycle busy drops.
        expect_res(MC, 32'd0, 32'd30);
        issue(OP_MULTU, 32'd5, 32'd6);
        n = 0;
        while (mif.busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        expect_res(DC, 32'd2, 32'd14);
        issue(OP_DIVU, 32'd100, 32'd7);
        drain();

        expect_res(MC, 32'd0, 32'd12);
        issue(OP_MULT, 32'd3, 32'd4);
        for (int i = 0; i < 6; i++) begin
            mif.a = $urandom;
            mif.b = $urandom;
            if (i == 0) begin
                mif.start = 1'b1;
                mif.md_op = OP_MTHI;
                mif.a     = 32'hDEADBEEF;
            end else if (i == 1) begin
                mif.start = 1'b1;
                mif.md_op = OP_DIV;
                mif.a     = 32'd9;
                mif.b     = 32'd3;
            end else begin
                mif.start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        mif.start = 1'b0;
        drain();
        busy_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (mif.busy) busy_seen++;
        end
        chk("no_extra_busy", 32'(busy_seen), 32'd0);
        chk("ignored_hi", mif.hi, 32'd0);
        @(posedge clk);
        #1;

        issue(OP_DIV, 32'd100, 32'd7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, mif.busy}, 32'd0);
        chk("async_rst_hi", mif.hi, 32'd0);
        chk("async_rst_lo", mif.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_res(MC, 32'd0, 32'd4);
        issue(OP_MULT, 32'd2, 32'd2);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
